// File: rtl/uart_receiver_fifo.sv
// 8N1 UART receiver with a 2-flop input synchroniser and a first-word-fall-through byte FIFO.
// Sticky frame-error and overrun flags are cleared by i_clr_err; a set on the same edge wins.
module uart_receiver_fifo #(
   parameter int unsigned clk_freq_hz = 12000000,
   parameter int unsigned baud_rate   = 9600,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   input  logic       i_clr_err,
   output logic       o_busy
);

   localparam int unsigned CPB  = clk_freq_hz / baud_rate;
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned CW   = $clog2(CPB);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] CntHalf = CW'(HALF - 1);
   localparam logic [CW-1:0] CntLast = CW'(CPB - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

   logic [1:0] sync_q;
   logic       rx_s;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          push_req;
   logic          frame_set;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        full, empty, do_pop, do_push, drop;
   logic        frame_err_q, overrun_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_rx};
      end
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      push_req  = 1'b0;
      frame_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == CntHalf) begin
               cnt_d = '0;
               idx_d = '0;
               // A line back high at mid start bit was only a glitch.
               state_d = rx_s ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (cnt_q == CntLast) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = '0;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  push_req = 1'b1;
                  state_d  = StIdle;
               end else begin
                  frame_set = 1'b1;
                  state_d   = StWaitHigh;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitHigh: begin
            if (rx_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop on the same edge frees the slot a full-FIFO push needs.
   assign do_pop  = !empty && i_ready;
   assign do_push = push_req && (!full || do_pop);
   assign drop    = push_req && full && !do_pop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (frame_set) begin
            frame_err_q <= 1'b1;
         end else if (i_clr_err) begin
            frame_err_q <= 1'b0;
         end
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (i_clr_err) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign o_data      = mem_q[rd_ptr_q[AW-1:0]];
   assign o_valid     = !empty;
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;
   assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Self-checking bench for uart_receiver_fifo: vector table, hand-written corner cases and a
// randomized run scored against a byte-list model of the receiver.
module tb_uart_receiver_fifo;

   localparam int unsigned ClkHz = 12000000;
   localparam int unsigned Baud  = 1000000;
   localparam int unsigned Depth = 4;
   localparam int Cpb     = ClkHz / Baud;
   localparam int Half    = Cpb / 2;
   localparam int PushOfs = 2 + Half + 9 * Cpb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, ovr, busy;

   uart_receiver_fifo #(
      .clk_freq_hz(ClkHz),
      .baud_rate  (Baud),
      .FIFO_DEPTH (Depth)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx       (rx),
      .o_data     (data),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_frame_err(ferr),
      .o_overrun  (ovr),
      .i_clr_err  (clr),
      .o_busy     (busy)
   );

   initial forever #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         edge_n = 0;
   int         t0_edge = 0;
   int         valid_rise_edge = 0;
   int         busy_rise_edge = 0;
   logic       valid_prev = 1'b0;
   logic       busy_prev = 1'b0;
   logic [7:0] popped[$];
   logic [7:0] acc[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;
   vec_t vecs[6];

   logic [7:0] pat;
   logic [7:0] rb;
   logic       rs;
   logic       exp_ferr, exp_ovr;
   int         rmode, gap;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Edge stamps for o_valid/o_busy rises and a log of every byte handed over by a pop.
   always @(negedge clk) begin
      valid_prev <= valid;
      busy_prev  <= busy;
      if (valid && !valid_prev) valid_rise_edge <= edge_n;
      if (busy && !busy_prev) busy_rise_edge <= edge_n;
      if (!rst && valid && ready) popped.push_back(data);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr;
      clr = 1'b1;
      tick;
      clr = 1'b0;
   endtask

   task automatic drain(input int n);
      ready = 1'b1;
      repeat (n) tick;
      ready = 1'b0;
   endtask

   // rmode < 0 leaves i_ready alone; 0 holds it low; 1 randomizes it outside the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rmode);
      t0_edge = edge_n + 1;
      for (int k = 0; k < 10; k++) begin
         rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
         for (int c = 0; c < Cpb; c++) begin
            if (rmode >= 0) ready = (k != 9) && (rmode == 1) && ($urandom_range(0, 1) == 1);
            tick;
         end
      end
   endtask

   function automatic int at(input int i);
      return (i < popped.size()) ? int'(popped[i]) : -1;
   endfunction

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
      vecs[3] = '{8'h81, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0};
      vecs[5] = '{8'h3E, 1'b0, 1'b0, 8'h00, 1'b1};

      repeat (3) tick;
      rst = 1'b0;
      check("reset valid", valid, 0);
      check("reset data", data, 0);
      check("reset frame_err", ferr, 0);
      check("reset overrun", ovr, 0);
      check("reset busy", busy, 0);

      for (int i = 0; i < 6; i++) begin
         popped.delete();
         send_frame(vecs[i].data, vecs[i].stop, 0);
         rx = 1'b1;
         repeat (6) tick;
         check($sformatf("vec%0d valid", i), valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d valid_rise", i), valid_rise_edge - t0_edge, PushOfs);
         end
         check($sformatf("vec%0d busy_rise", i), busy_rise_edge - t0_edge, 2);
         check($sformatf("vec%0d frame_err", i), ferr, vecs[i].exp_ferr);
         check($sformatf("vec%0d overrun", i), ovr, 0);
         check($sformatf("vec%0d busy", i), busy, 0);
         pulse_clr;
         drain(2);
      end

      // Back-to-back frames with the reader always ready.
      popped.delete();
      ready = 1'b1;
      send_frame(8'hA5, 1'b1, -1);
      send_frame(8'h3C, 1'b1, -1);
      rx = 1'b1;
      repeat (6) tick;
      ready = 1'b0;
      check("b2b pops", popped.size(), 2);
      check("b2b pop0", at(0), 'hA5);
      check("b2b pop1", at(1), 'h3C);
      check("b2b valid", valid, 0);
      check("b2b errors", {ferr, ovr}, 0);

      // Low stop bit followed by a break.
      popped.delete();
      send_frame(8'h81, 1'b0, 0);
      repeat (40) tick;
      check("break busy", busy, 1);
      check("break frame_err", ferr, 1);
      check("break valid", valid, 0);
      rx = 1'b1;
      repeat (6) tick;
      check("break idle busy", busy, 0);
      check("break no byte", valid, 0);
      check("break pops", popped.size(), 0);
      pulse_clr;
      check("break clr", ferr, 0);

      // Three-cycle low glitch on an idle line.
      t0_edge = edge_n + 1;
      rx = 1'b0;
      repeat (3) tick;
      rx = 1'b1;
      repeat (7) tick;
      check("glitch detected", busy_rise_edge - t0_edge, 2);
      check("glitch busy", busy, 0);
      check("glitch valid", valid, 0);
      check("glitch flags", {ferr, ovr}, 0);

      // Five frames into a four-entry FIFO.
      popped.delete();
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 0);
      rx = 1'b1;
      repeat (4) tick;
      check("ovr flag", ovr, 1);
      check("ovr head", data, 1);
      check("ovr frame_err", ferr, 0);
      drain(8);
      check("ovr pops", popped.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("ovr pop%0d", i), at(i), i + 1);
      check("ovr empty", valid, 0);
      pulse_clr;

      // Reset during data bit 4 of 0xF0 with a byte already queued.
      send_frame(8'h77, 1'b1, 0);
      rx = 1'b1;
      repeat (2) tick;
      check("pre-reset valid", valid, 1);
      pat = 8'hF0;
      rx = 1'b0;
      repeat (Cpb) tick;
      for (int k = 0; k < 4; k++) begin
         rx = pat[k];
         repeat (Cpb) tick;
      end
      rx = pat[4];
      repeat (Half) tick;
      rst = 1'b1;
      rx = 1'b1;
      tick;
      rst = 1'b0;
      check("midrst valid", valid, 0);
      check("midrst data", data, 0);
      check("midrst frame_err", ferr, 0);
      check("midrst overrun", ovr, 0);
      check("midrst busy", busy, 0);
      repeat (3 * Cpb) tick;
      check("midrst nothing pushed", valid, 0);
      check("midrst still idle", busy, 0);
      popped.delete();
      send_frame(8'h5A, 1'b1, 0);
      rx = 1'b1;
      repeat (4) tick;
      check("midrst next valid", valid, 1);
      check("midrst next data", data, 'h5A);
      drain(2);

      // Randomized frames, gaps, reader behaviour and flag clears against a byte-list model.
      rst = 1'b1;
      repeat (2) tick;
      rst = 1'b0;
      popped.delete();
      acc.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      for (int n = 0; n < 40; n++) begin
         rmode = ($urandom_range(0, 2) == 0) ? 0 : 1;
         gap = $urandom_range(0, 15);
         rx = 1'b1;
         for (int g = 0; g < gap; g++) begin
            ready = (rmode == 1) && ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 7) == 0);
            if (clr) begin
               exp_ferr = 1'b0;
               exp_ovr  = 1'b0;
            end
            tick;
         end
         clr = 1'b0;
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 9) != 0);
         send_frame(rb, rs, rmode);
         if (rs) begin
            if (acc.size() - popped.size() < int'(Depth)) acc.push_back(rb);
            else exp_ovr = 1'b1;
         end else begin
            exp_ferr = 1'b1;
            rx = 1'b1;
            repeat (Cpb) tick;
         end
      end
      rx = 1'b1;
      repeat (2) tick;
      drain(Depth + 2);
      check("rand pop count", popped.size(), acc.size());
      for (int i = 0; i < acc.size(); i++) check($sformatf("rand pop%0d", i), at(i), acc[i]);
      check("rand frame_err", ferr, exp_ferr);
      check("rand overrun", ovr, exp_ovr);
      check("rand empty", valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
